// File: rtl/mem_pkg.sv
// Shared types for the LEGv8 MEM stage: FSM states, access size codes, lane masks.
// No logic of its own; latency and backpressure belong to the users.
package mem_pkg;

    localparam int WORD = 64;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } mem_state_e;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    // Byte-lane mask for an access of the given size at lane offset 0.
    function automatic logic [7:0] lane_mask(input logic [1:0] size);
        logic [7:0] mask;
        case (size)
            SZ_B:    mask = 8'h01;
            SZ_H:    mask = 8'h03;
            SZ_W:    mask = 8'h0F;
            default: mask = 8'hFF;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/mem_align.sv
// Lane steering for data memory: byte enables, store shift, load extract/extend, alignment check.
// Purely combinational, zero latency; no flow control.
module mem_align
    import mem_pkg::*;
(
    input  logic [2:0]      offset,
    input  logic [1:0]      size,
    input  logic            sext,
    input  logic [WORD-1:0] st_data,
    input  logic [WORD-1:0] ld_raw,
    output logic [7:0]      be,
    output logic [WORD-1:0] st_lane,
    output logic [WORD-1:0] ld_data,
    output logic            misaligned
);

    logic [5:0]      shamt;
    logic [WORD-1:0] shifted;
    logic            fill;

    always_comb begin
        shamt   = {offset, 3'b000};
        be      = lane_mask(size) << offset;
        st_lane = st_data << shamt;
        shifted = ld_raw >> shamt;
        fill    = 1'b0;
        ld_data = shifted;
        case (size)
            SZ_B: begin
                fill    = sext & shifted[7];
                ld_data = {{(WORD-8){fill}}, shifted[7:0]};
            end
            SZ_H: begin
                fill    = sext & shifted[15];
                ld_data = {{(WORD-16){fill}}, shifted[15:0]};
            end
            SZ_W: begin
                fill    = sext & shifted[31];
                ld_data = {{(WORD-32){fill}}, shifted[31:0]};
            end
            default: ld_data = shifted;
        endcase
    end

    always_comb begin
        case (size)
            SZ_B:    misaligned = 1'b0;
            SZ_H:    misaligned = offset[0];
            SZ_W:    misaligned = |offset[1:0];
            default: misaligned = |offset;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// LEGv8 MEM stage: runs loads/stores over a valid/ready data-memory port and registers MEM/WB.
// Non-memory ops reach WB one cycle later; memory ops take REQ/RESP cycles until the port responds or times out.
// stall holds the upstream pipeline for the whole access and drops in the completing (or aborting) cycle.
module mem_access
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    input  logic [WORD-1:0] ex_ALUOut,
    input  logic [WORD-1:0] ex_r_data2,
    input  logic [WORD-1:0] ex_pc_incr,
    input  logic            ex_MemRead,
    input  logic            ex_MemWrite,
    input  logic [1:0]      ex_size,
    input  logic            ex_signed,
    input  logic [1:0]      ex_MemtoReg,
    input  logic [31:0]     ex_inst,
    output logic            stall,
    output logic            dm_req,
    output logic            dm_we,
    output logic [WORD-1:0] dm_addr,
    output logic [7:0]      dm_be,
    output logic [WORD-1:0] dm_wdata,
    input  logic            dm_ready,
    input  logic            dm_rvalid,
    input  logic [WORD-1:0] dm_rdata,
    output logic            wb_valid,
    output logic [WORD-1:0] wb_ALUOut,
    output logic [WORD-1:0] wb_r_data,
    output logic [WORD-1:0] wb_pc_incr,
    output logic [WORD-1:0] wb_r_data2,
    output logic [1:0]      wb_MemtoReg,
    output logic [31:0]     wb_inst,
    output logic            err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    mem_state_e      state, state_nxt;
    logic [CNT_W-1:0] cnt;

    logic            is_mem;
    logic            misaligned;
    logic [7:0]      be;
    logic [WORD-1:0] st_lane;
    logic [WORD-1:0] ld_data;

    logic alu_done, st_done, ld_done, done, abort, mis_evt;

    assign is_mem = ex_valid & (ex_MemRead | ex_MemWrite);

    mem_align u_align (
        .offset     (ex_ALUOut[2:0]),
        .size       (ex_size),
        .sext       (ex_signed),
        .st_data    (ex_r_data2),
        .ld_raw     (dm_rdata),
        .be         (be),
        .st_lane    (st_lane),
        .ld_data    (ld_data),
        .misaligned (misaligned)
    );

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        dm_req    = 1'b0;
        alu_done  = 1'b0;
        st_done   = 1'b0;
        ld_done   = 1'b0;
        abort     = 1'b0;
        mis_evt   = 1'b0;
        case (state)
            IDLE: begin
                if (is_mem) begin
                    stall = 1'b1;
                    if (misaligned) mis_evt = 1'b1;
                    else            state_nxt = REQ;
                end else if (ex_valid) begin
                    alu_done = 1'b1;
                end
            end
            REQ: begin
                dm_req = 1'b1;
                if (dm_ready) begin
                    if (ex_MemWrite)    st_done   = 1'b1;
                    else if (dm_rvalid) ld_done   = 1'b1;
                    else                state_nxt = RESP;
                end
            end
            RESP: begin
                if (dm_rvalid) ld_done = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase

        done = st_done | ld_done;
        if (state != IDLE) begin
            // The cycle budget spans REQ and RESP together.
            if (!done && cnt == CNT_W'(TIMEOUT - 1)) abort = 1'b1;
            if (done || abort) state_nxt = IDLE;
            stall = ~(done | abort);
        end
    end

    assign dm_we    = dm_req & ex_MemWrite;
    assign dm_addr  = dm_req ? {ex_ALUOut[WORD-1:3], 3'b000} : '0;
    assign dm_be    = dm_req ? be : 8'h00;
    assign dm_wdata = dm_req ? st_lane : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            err         <= 1'b0;
            wb_valid    <= 1'b0;
            wb_ALUOut   <= '0;
            wb_r_data   <= '0;
            wb_pc_incr  <= '0;
            wb_r_data2  <= '0;
            wb_MemtoReg <= '0;
            wb_inst     <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE)  cnt <= '0;
            else                cnt <= cnt + 1'b1;
            err      <= mis_evt | abort;
            wb_valid <= alu_done | done;
            if (alu_done | done) begin
                wb_ALUOut   <= ex_ALUOut;
                wb_r_data   <= ld_done ? ld_data : '0;
                wb_pc_incr  <= ex_pc_incr;
                wb_r_data2  <= ex_r_data2;
                wb_MemtoReg <= ex_MemtoReg;
                wb_inst     <= ex_inst;
            end
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: ALU pass-through, loads/stores, misalignment, timeout, async reset.
module tb_mem_access;
    import mem_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            ex_valid, ex_MemRead, ex_MemWrite, ex_signed;
    logic [WORD-1:0] ex_ALUOut, ex_r_data2, ex_pc_incr;
    logic [1:0]      ex_size, ex_MemtoReg;
    logic [31:0]     ex_inst;
    logic            stall, dm_req, dm_we, dm_ready, dm_rvalid;
    logic [WORD-1:0] dm_addr, dm_wdata, dm_rdata;
    logic [7:0]      dm_be;
    logic            wb_valid, err;
    logic [WORD-1:0] wb_ALUOut, wb_r_data, wb_pc_incr, wb_r_data2;
    logic [1:0]      wb_MemtoReg;
    logic [31:0]     wb_inst;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_access dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ALUOut(ex_ALUOut), .ex_r_data2(ex_r_data2),
        .ex_pc_incr(ex_pc_incr), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
        .ex_size(ex_size), .ex_signed(ex_signed), .ex_MemtoReg(ex_MemtoReg), .ex_inst(ex_inst),
        .stall(stall), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
        .dm_wdata(dm_wdata), .dm_ready(dm_ready), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .wb_valid(wb_valid), .wb_ALUOut(wb_ALUOut), .wb_r_data(wb_r_data),
        .wb_pc_incr(wb_pc_incr), .wb_r_data2(wb_r_data2), .wb_MemtoReg(wb_MemtoReg),
        .wb_inst(wb_inst), .err(err)
    );

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ex;
        ex_valid = 0; ex_MemRead = 0; ex_MemWrite = 0; ex_signed = 0;
        ex_ALUOut = '0; ex_r_data2 = '0; ex_pc_incr = '0; ex_size = 2'b00;
        ex_MemtoReg = 2'b00; ex_inst = '0;
    endtask

    task automatic set_mem(input logic rd, input logic wr, input logic [63:0] addr,
                           input logic [63:0] data, input logic [1:0] sz, input logic sg);
        ex_valid = 1; ex_MemRead = rd; ex_MemWrite = wr; ex_ALUOut = addr;
        ex_r_data2 = data; ex_size = sz; ex_signed = sg; ex_pc_incr = 64'h1000;
        ex_MemtoReg = 2'b01; ex_inst = 32'hF840_0000;
    endtask

    task automatic test_reset;
        #3;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", stall); end
        total++; if (dm_req !== 1'b0) begin bad++; $display("FAIL rst_dm_req got=%b exp=0", dm_req); end
        total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL rst_wb_valid got=%b exp=0", wb_valid); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", err); end
        total++; if (wb_ALUOut !== 64'h0) begin bad++; $display("FAIL rst_wb_alu got=%h exp=0", wb_ALUOut); end
        @(posedge clk); #1 rst_n = 1;
    endtask

    task automatic test_alu;
        cyc();
        ex_valid = 1; ex_ALUOut = 64'd100; ex_pc_incr = 64'd104; ex_inst = 32'h8B02_0020;
        ex_MemtoReg = 2'b00;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL alu_stall got=%b exp=0", stall); end
        cyc();
        clear_ex();
        #1;
        total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL alu_wb_valid got=%b exp=1", wb_valid); end
        total++; if (wb_ALUOut !== 64'd100) begin bad++; $display("FAIL alu_wb_alu got=%0d exp=100", wb_ALUOut); end
        total++; if (wb_pc_incr !== 64'd104) begin bad++; $display("FAIL alu_wb_pc got=%0d exp=104", wb_pc_incr); end
        total++; if (wb_inst !== 32'h8B02_0020) begin bad++; $display("FAIL alu_wb_inst got=%h exp=8b020020", wb_inst); end
        cyc();
        total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL alu_bubble got=%b exp=0", wb_valid); end
    endtask

    task automatic test_ldur_d;
        int stalls = 0;
        cyc();
        set_mem(1, 0, 64'h40, 64'h0, SZ_D, 0);
        for (int k = 0; k < 9; k++) begin
            if (k > 0) cyc();
            dm_ready  = (k == 3);
            dm_rvalid = (k == 6);
            dm_rdata  = (k == 6) ? 64'd90 : 64'h0;
            if (k >= 7) clear_ex();
            #1;
            if (stall === 1'b1) stalls++;
            if (k == 3) begin
                total++; if (dm_req !== 1'b1) begin bad++; $display("FAIL ld_req got=%b exp=1", dm_req); end
                total++; if (dm_addr !== 64'h40) begin bad++; $display("FAIL ld_addr got=%h exp=40", dm_addr); end
                total++; if (dm_be !== 8'hFF || dm_we !== 1'b0) begin bad++; $display("FAIL ld_be_we got=%h/%b exp=ff/0", dm_be, dm_we); end
            end
            if (k == 5) begin
                total++; if (dm_req !== 1'b0) begin bad++; $display("FAIL ld_resp_req got=%b exp=0", dm_req); end
                total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL ld_wait_bubble got=%b exp=0", wb_valid); end
            end
            if (k == 7) begin
                total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL ld_wb_valid got=%b exp=1", wb_valid); end
                total++; if (wb_r_data !== 64'd90) begin bad++; $display("FAIL ld_wb_rdata got=%0d exp=90", wb_r_data); end
            end
        end
        total++; if (stalls != 6) begin bad++; $display("FAIL ld_stall_cycles got=%0d exp=6", stalls); end
    endtask

    task automatic test_sturb;
        cyc();
        set_mem(0, 1, 64'h43, 64'hAB, SZ_B, 0);
        #1;
        total++; if (stall !== 1'b1 || dm_req !== 1'b0) begin bad++; $display("FAIL st_idle got=%b/%b exp=1/0", stall, dm_req); end
        cyc();
        dm_ready = 1;
        #1;
        total++; if (dm_req !== 1'b1 || dm_we !== 1'b1) begin bad++; $display("FAIL st_req_we got=%b/%b exp=1/1", dm_req, dm_we); end
        total++; if (dm_be !== 8'h08) begin bad++; $display("FAIL st_be got=%h exp=08", dm_be); end
        total++; if (dm_wdata !== 64'h0000_0000_AB00_0000) begin bad++; $display("FAIL st_wdata got=%h exp=ab000000", dm_wdata); end
        total++; if (dm_addr !== 64'h40) begin bad++; $display("FAIL st_addr got=%h exp=40", dm_addr); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL st_stall_drop got=%b exp=0", stall); end
        cyc();
        dm_ready = 0;
        clear_ex();
        #1;
        total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL st_wb_valid got=%b exp=1", wb_valid); end
        total++; if (dm_req !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL st_no_resp got=%b/%b exp=0/0", dm_req, stall); end
    endtask

    task automatic test_load_extend;
        logic [63:0] va [0:2];
        logic [1:0]  vs [0:2];
        logic        vg [0:2];
        logic [63:0] vr [0:2];
        logic [7:0]  vb [0:2];
        logic [63:0] ve [0:2];
        va[0] = 64'h44; vs[0] = SZ_W; vg[0] = 1; vr[0] = 64'hFFFF_FFFE_0000_0000; vb[0] = 8'hF0; ve[0] = 64'hFFFF_FFFF_FFFF_FFFE;
        va[1] = 64'h46; vs[1] = SZ_H; vg[1] = 0; vr[1] = 64'h8001_0000_0000_0000; vb[1] = 8'hC0; ve[1] = 64'h0000_0000_0000_8001;
        va[2] = 64'h41; vs[2] = SZ_B; vg[2] = 1; vr[2] = 64'h0000_0000_0000_8000; vb[2] = 8'h02; ve[2] = 64'hFFFF_FFFF_FFFF_FF80;
        for (int i = 0; i < 3; i++) begin
            cyc();
            set_mem(1, 0, va[i], 64'h0, vs[i], vg[i]);
            cyc();
            dm_ready = 1; dm_rvalid = 1; dm_rdata = vr[i];
            #1;
            total++; if (dm_be !== vb[i]) begin bad++; $display("FAIL ext_be[%0d] got=%h exp=%h", i, dm_be, vb[i]); end
            total++; if (stall !== 1'b0) begin bad++; $display("FAIL ext_stall[%0d] got=%b exp=0", i, stall); end
            cyc();
            dm_ready = 0; dm_rvalid = 0; dm_rdata = '0;
            clear_ex();
            #1;
            total++; if (wb_valid !== 1'b1 || wb_r_data !== ve[i]) begin bad++; $display("FAIL ext_rdata[%0d] got=%b/%h exp=1/%h", i, wb_valid, wb_r_data, ve[i]); end
        end
    endtask

    task automatic test_misaligned;
        cyc();
        set_mem(1, 0, 64'h42, 64'h0, SZ_W, 0);
        #1;
        total++; if (dm_req !== 1'b0) begin bad++; $display("FAIL mis_req got=%b exp=0", dm_req); end
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL mis_stall got=%b exp=1", stall); end
        cyc();
        clear_ex();
        #1;
        total++; if (err !== 1'b1) begin bad++; $display("FAIL mis_err got=%b exp=1", err); end
        total++; if (wb_valid !== 1'b0 || dm_req !== 1'b0) begin bad++; $display("FAIL mis_wb got=%b/%b exp=0/0", wb_valid, dm_req); end
        cyc();
        total++; if (err !== 1'b0) begin bad++; $display("FAIL mis_err_pulse got=%b exp=0", err); end
    endtask

    task automatic test_timeout;
        int early = 0;
        cyc();
        set_mem(1, 0, 64'h80, 64'h0, SZ_D, 0);
        dm_ready = 0;
        for (int k = 1; k <= 255; k++) begin
            cyc();
            #1;
            if (err === 1'b1) early++;
            if (k == 255) begin
                total++; if (dm_req !== 1'b1) begin bad++; $display("FAIL to_last_req got=%b exp=1", dm_req); end
            end
        end
        total++; if (early != 0) begin bad++; $display("FAIL to_early_err got=%0d exp=0", early); end
        cyc();
        clear_ex();
        #1;
        total++; if (err !== 1'b1) begin bad++; $display("FAIL to_err got=%b exp=1", err); end
        total++; if (dm_req !== 1'b0 || stall !== 1'b0 || wb_valid !== 1'b0) begin bad++; $display("FAIL to_idle got=%b/%b/%b exp=0/0/0", dm_req, stall, wb_valid); end
        cyc();
        total++; if (err !== 1'b0) begin bad++; $display("FAIL to_err_pulse got=%b exp=0", err); end
    endtask

    task automatic test_reset_mid;
        cyc();
        set_mem(1, 0, 64'h10, 64'h0, SZ_D, 0);
        cyc();
        dm_ready = 1;
        cyc();
        dm_ready = 0;
        #1;
        total++; if (dm_req !== 1'b0 || stall !== 1'b1) begin bad++; $display("FAIL rm_resp got=%b/%b exp=0/1", dm_req, stall); end
        #1 rst_n = 0;
        clear_ex();
        dm_rvalid = 1; dm_rdata = 64'h55;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL rm_idle_stall got=%b exp=0", stall); end
        cyc();
        dm_rvalid = 0;
        rst_n = 1;
        #1;
        total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL rm_no_complete got=%b exp=0", wb_valid); end
        set_mem(1, 0, 64'h18, 64'h0, SZ_D, 0);
        cyc();
        #1;
        total++; if (dm_req !== 1'b1) begin bad++; $display("FAIL rm_restart_req got=%b exp=1", dm_req); end
        dm_ready = 1; dm_rvalid = 1; dm_rdata = 64'h77;
        cyc();
        dm_ready = 0; dm_rvalid = 0;
        clear_ex();
        #1;
        total++; if (wb_valid !== 1'b1 || wb_r_data !== 64'h77) begin bad++; $display("FAIL rm_restart_wb got=%b/%h exp=1/77", wb_valid, wb_r_data); end
    endtask

    initial begin
        rst_n = 0;
        clear_ex();
        dm_ready = 0; dm_rvalid = 0; dm_rdata = '0;
        test_reset();
        test_alu();
        test_ldur_d();
        test_sturb();
        test_load_extend();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
